// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD accumulator.
//   DIGIT_W        : bits per packed BCD digit
//   BCD_MAX        : largest legal BCD digit value
//   state_t        : controller states
//   bcd_digit_valid: true when a 4-bit value is a legal BCD digit
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic bcd_digit_valid(input logic [DIGIT_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational mod-10 digit adder with carry.
//   a, b : BCD digit operands (0..9)
//   cin  : carry in
//   s    : BCD sum digit
//   cout : carry out (digit sum was 10..19)
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   logic [DIGIT_W:0] sum;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
      s    = sum[DIGIT_W-1:0];
      cout = 1'b0;
      if (sum > {1'b0, BCD_MAX}) begin
         // Subtracting 10 on the low nibble alone is exact modulo 16 for 10..19.
         s    = sum[DIGIT_W-1:0] - 4'd10;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_accumulator_ctrl.sv
// Serial multi-digit BCD accumulator controller. Each accepted operand is
// added into the accumulator one digit per cycle, LSD first, through a single
// shared digit adder.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear/abort
//   in_valid/in_ready/in_data : operand handshake, packed BCD
//   acc        : accumulator (packed BCD)
//   out_valid  : one-cycle pulse, acc holds a completed sum
//   overflow   : sticky carry out of the MSD
//   err        : one-cycle pulse, operand rejected (non-BCD digit)
//   busy       : high in ADD and DONE
module bcd_accumulator_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIGIT_W*DIGITS-1:0] in_data,
   output logic [DIGIT_W*DIGITS-1:0] acc,
   output logic                      out_valid,
   output logic                      overflow,
   output logic                      err,
   output logic                      busy
);

   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t                    state;
   logic [IDX_W-1:0]          idx;
   logic                      carry;
   logic [DIGIT_W*DIGITS-1:0] op_q;

   logic                      in_bcd_ok;
   logic [DIGIT_W-1:0]        acc_digit;
   logic [DIGIT_W-1:0]        op_digit;
   logic [DIGIT_W-1:0]        sum_digit;
   logic                      sum_cout;

   always_comb begin
      in_bcd_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!bcd_digit_valid(in_data[i*DIGIT_W +: DIGIT_W])) begin
            in_bcd_ok = 1'b0;
         end
      end
   end

   always_comb begin
      acc_digit = acc[int'(idx)*DIGIT_W +: DIGIT_W];
      op_digit  = op_q[int'(idx)*DIGIT_W +: DIGIT_W];
   end

   bcd_digit_add u_digit_add (
      .a    (acc_digit),
      .b    (op_digit),
      .cin  (carry),
      .s    (sum_digit),
      .cout (sum_cout)
   );

   assign in_ready  = (state == IDLE) && !clear;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         op_q     <= '0;
         acc      <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (clear) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            overflow <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (in_valid) begin
                     if (in_bcd_ok) begin
                        op_q  <= in_data;
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= ADD;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               ADD: begin
                  acc[int'(idx)*DIGIT_W +: DIGIT_W] <= sum_digit;
                  carry <= sum_cout;
                  if (idx == LAST_IDX) begin
                     idx      <= '0;
                     overflow <= overflow | sum_cout;
                     state    <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_accumulator_ctrl.sv
module tb_bcd_accumulator_ctrl;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [15:0] acc;
   logic        out_valid;
   logic        overflow;
   logic        err;
   logic        busy;

   int tests;
   int failed;
   int cycle;

   bcd_accumulator_ctrl #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .acc       (acc),
      .out_valid (out_valid),
      .overflow  (overflow),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Offer one operand from a negedge; returns cycles from the accept cycle
   // to the out_valid cycle, and whether out_valid was seen at all.
   task automatic send(input logic [15:0] d, output int lat, output logic got);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         lat++;
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #12;
      tests++;
      if (acc !== 16'h0000 || overflow !== 1'b0 || out_valid !== 1'b0 ||
          err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_values: acc=%h ov=%b ov_v=%b err=%b busy=%b rdy=%b expected 0000 0 0 0 0 1",
                  acc, overflow, out_valid, err, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_add();
      int   lat;
      logic got;
      send(16'h0123, lat, got);
      tests++;
      if (got !== 1'b1 || lat != 5 || acc !== 16'h0123) begin
         failed++;
         $display("FAIL basic_first: got=%b lat=%0d acc=%h expected 1 5 0123", got, lat, acc);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failed++;
         $display("FAIL basic_pulse_width: ov_v=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
      end
      send(16'h0456, lat, got);
      tests++;
      if (got !== 1'b1 || lat != 5 || acc !== 16'h0579 || overflow !== 1'b0) begin
         failed++;
         $display("FAIL basic_second: got=%b lat=%0d acc=%h ov=%b expected 1 5 0579 0", got, lat, acc, overflow);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset_mid_add();
      in_data  = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL areset_busy_before: busy=%b expected 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (acc !== 16'h0000 || overflow !== 1'b0 || busy !== 1'b0 ||
          in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL areset_mid_add: acc=%h ov=%b busy=%b rdy=%b ov_v=%b expected 0000 0 0 1 0",
                  acc, overflow, busy, in_ready, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_carry_wrap();
      int   lat;
      logic got;
      send(16'h0999, lat, got);
      tests++;
      if (got !== 1'b1 || acc !== 16'h0999 || overflow !== 1'b0) begin
         failed++;
         $display("FAIL carry_load: got=%b acc=%h ov=%b expected 1 0999 0", got, acc, overflow);
      end
      send(16'h0001, lat, got);
      tests++;
      if (got !== 1'b1 || acc !== 16'h1000 || overflow !== 1'b0) begin
         failed++;
         $display("FAIL carry_ripple: got=%b acc=%h ov=%b expected 1 1000 0", got, acc, overflow);
      end
      send(16'h9000, lat, got);
      tests++;
      if (got !== 1'b1 || acc !== 16'h0000 || overflow !== 1'b1) begin
         failed++;
         $display("FAIL carry_wrap: got=%b acc=%h ov=%b expected 1 0000 1", got, acc, overflow);
      end
      send(16'h0001, lat, got);
      tests++;
      if (got !== 1'b1 || acc !== 16'h0001 || overflow !== 1'b1) begin
         failed++;
         $display("FAIL overflow_sticky: got=%b acc=%h ov=%b expected 1 0001 1", got, acc, overflow);
      end
      @(negedge clk);
   endtask

   task automatic test_invalid_digit();
      int   lat;
      logic got;
      int   errs;
      int   ovs;
      in_data  = 16'h00A1;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (err !== 1'b1 || acc !== 16'h0001 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL invalid_err: err=%b acc=%h busy=%b rdy=%b expected 1 0001 0 1", err, acc, busy, in_ready);
      end
      errs = 0;
      ovs  = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (err)       errs++;
         if (out_valid) ovs++;
      end
      tests++;
      if (errs != 0 || ovs != 0 || acc !== 16'h0001) begin
         failed++;
         $display("FAIL invalid_quiet: extra_err=%0d out_valid=%0d acc=%h expected 0 0 0001", errs, ovs, acc);
      end
      send(16'h0002, lat, got);
      tests++;
      if (got !== 1'b1 || lat != 5 || acc !== 16'h0003) begin
         failed++;
         $display("FAIL invalid_recover: got=%b lat=%0d acc=%h expected 1 5 0003", got, lat, acc);
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      int ovs;
      // Abort while the third digit (idx = 2) is being written.
      in_data  = 16'h1234;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      tests++;
      if (acc !== 16'h0000 || overflow !== 1'b0 || busy !== 1'b0 ||
          in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL clear_abort: acc=%h ov=%b busy=%b rdy=%b ov_v=%b expected 0000 0 0 1 0",
                  acc, overflow, busy, in_ready, out_valid);
      end
      ovs = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid || err || busy) ovs++;
      end
      tests++;
      if (ovs != 0) begin
         failed++;
         $display("FAIL clear_quiet: activity_cycles=%0d expected 0", ovs);
      end
      // clear wins over an operand offered in IDLE.
      in_data  = 16'h0005;
      in_valid = 1'b1;
      clear    = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         failed++;
         $display("FAIL clear_ready: in_ready=%b expected 0", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || acc !== 16'h0000 || err !== 1'b0) begin
         failed++;
         $display("FAIL clear_no_accept: busy=%b acc=%h err=%b expected 0 0000 0", busy, acc, err);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          acc_cyc [3];
      logic [15:0] acc_val [3];
      int          na;
      int          nv;
      logic [15:0] exp_v;
      na = 0;
      nv = 0;
      in_data  = 16'h0001;
      in_valid = 1'b1;
      for (int k = 0; k < 40 && nv < 3; k++) begin
         #1;
         if (in_valid && in_ready && na < 3) begin
            acc_cyc[na] = cycle;
            na++;
         end
         @(negedge clk);
         if (out_valid) begin
            acc_val[nv] = acc;
            nv++;
            if (nv == 3) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      tests++;
      if (na < 3 || nv != 3) begin
         failed++;
         $display("FAIL b2b_count: accepts=%0d out_valids=%0d expected >=3 3", na, nv);
      end else begin
         for (int j = 0; j < 3; j++) begin
            exp_v = 16'h0001 + 16'(j);
            tests++;
            if (acc_val[j] !== exp_v) begin
               failed++;
               $display("FAIL b2b_acc%0d: acc=%h expected %h", j, acc_val[j], exp_v);
            end
         end
         for (int j = 1; j < 3; j++) begin
            tests++;
            if (acc_cyc[j] - acc_cyc[j-1] != 6) begin
               failed++;
               $display("FAIL b2b_spacing%0d: cycles=%0d expected 6", j, acc_cyc[j] - acc_cyc[j-1]);
            end
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_basic_add();
      test_async_reset_mid_add();
      test_carry_wrap();
      test_invalid_digit();
      test_clear();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
